// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the integer pipeline: datapath width, register
// address width and the writeback request record used between execute, the
// LSU and the register file write port.
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;
    localparam int WB_REQ_W   = REG_ADDR_W + XLEN;

    // One pending register write: destination and value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    // x0 is hardwired to zero, so a write aimed at it never reaches the file.
    function automatic logic writes_reg(input logic [REG_ADDR_W-1:0] rd);
        return rd != '0;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered occupancy and a combinational head.
// Pushes while full and pops while empty are ignored.
//
// Parameters
//   WIDTH  entry width in bits
//   DEPTH  number of entries; power of two, >= 2
// Ports
//   clk    in   clock
//   rst    in   synchronous active-high reset (empties the FIFO)
//   push   in   write wdata at the tail this cycle
//   pop    in   remove the head this cycle
//   wdata  in   data to push
//   rdata  out  current head entry (valid when !empty)
//   full   out  DEPTH entries held
//   empty  out  no entries held
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers are exactly log2(DEPTH) bits, so they wrap without any
    // explicit compare; the extra count bit distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once the count says so.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/int_reg_wb.sv
// ----------------------------------------------------------------------------
// int_reg_wb
// Writeback arbiter and write-port driver for int_reg. Merges single-cycle
// ALU results with buffered load returns onto the single rd write port, and
// keeps a load scoreboard so decode can stall on registers whose load has
// not yet been written back. Datapath width comes from cpu_pkg::XLEN.
//
// Parameters
//   LQ_DEPTH   load-result queue entries; power of two, >= 2
// Ports
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   alu_valid  in   ALU result present; always accepted
//   alu_rd     in   ALU destination register
//   alu_data   in   ALU result
//   lsu_valid  in   load result offered
//   lsu_ready  out  load result accepted when lsu_valid && lsu_ready
//   lsu_rd     in   load destination register
//   lsu_data   in   load data
//   iss_load   in   a load to iss_rd is issued this cycle
//   iss_rd     in   destination of the issued load
//   rs1_addr   in   decode source 1 for the busy lookup
//   rs2_addr   in   decode source 2 for the busy lookup
//   rs1_busy   out  rs1_addr has a pending load (combinational)
//   rs2_busy   out  rs2_addr has a pending load (combinational)
//   rd_wen     out  registered write enable to int_reg
//   rd_addr    out  registered write address
//   rd_wdata   out  registered write data
// ----------------------------------------------------------------------------
module int_reg_wb
    import cpu_pkg::*;
#(
    parameter int LQ_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    input  logic                  iss_load,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  rd_wen,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic [XLEN-1:0]       rd_wdata
);

    wb_req_t               lsu_req;
    wb_req_t               lq_head;
    logic [WB_REQ_W-1:0]   lq_rdata;
    logic                  lq_full;
    logic                  lq_empty;
    logic                  lq_push;
    logic                  lq_pop;

    wb_req_t               sel_req;
    logic                  sel_valid;

    logic [NUM_REGS-1:1]   busy;
    logic [NUM_REGS-1:1]   busy_next;
    logic [NUM_REGS-1:0]   busy_vec;
    logic [NUM_REGS-1:0]   busy_vec_next;

    assign lsu_req.rd   = lsu_rd;
    assign lsu_req.data = lsu_data;
    assign lq_head      = lq_rdata;

    // Readiness depends only on the registered occupancy: a pop in this
    // cycle frees a slot for the next cycle, not this one.
    assign lsu_ready = !lq_full;
    assign lq_push   = lsu_valid && lsu_ready;

    sync_fifo #(
        .WIDTH (WB_REQ_W),
        .DEPTH (LQ_DEPTH)
    ) u_load_q (
        .clk   (clk),
        .rst   (rst),
        .push  (lq_push),
        .pop   (lq_pop),
        .wdata (lsu_req),
        .rdata (lq_rdata),
        .full  (lq_full),
        .empty (lq_empty)
    );

    // ALU results have absolute priority; the queue only drains in cycles
    // with no ALU traffic. A load is popped even when it targets x0.
    always_comb begin
        sel_valid = 1'b0;
        sel_req   = '0;
        lq_pop    = 1'b0;
        if (alu_valid) begin
            sel_valid    = 1'b1;
            sel_req.rd   = alu_rd;
            sel_req.data = alu_data;
        end else if (!lq_empty) begin
            sel_valid = 1'b1;
            sel_req   = lq_head;
            lq_pop    = 1'b1;
        end
    end

    // Write port registers. Address and data hold when nothing is selected.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_wen   <= 1'b0;
            rd_addr  <= '0;
            rd_wdata <= '0;
        end else if (sel_valid) begin
            rd_wen   <= writes_reg(sel_req.rd);
            rd_addr  <= sel_req.rd;
            rd_wdata <= sel_req.data;
        end else begin
            rd_wen   <= 1'b0;
        end
    end

    // The scoreboard is handled as a full 32-entry vector with bit 0 tied
    // low, so x0 set/clear/lookups fall out naturally and are discarded.
    // The issue-side set is applied after the pop-side clear so that a new
    // load to the same register keeps it busy.
    assign busy_vec = {busy, 1'b0};

    always_comb begin
        busy_vec_next = busy_vec;
        if (lq_pop) begin
            busy_vec_next[lq_head.rd] = 1'b0;
        end
        if (iss_load) begin
            busy_vec_next[iss_rd] = 1'b1;
        end
        busy_next = busy_vec_next[NUM_REGS-1:1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign rs1_busy = busy_vec[rs1_addr];
    assign rs2_busy = busy_vec[rs2_addr];

endmodule

// File: tb/tb_int_reg_wb.sv
// ----------------------------------------------------------------------------
// tb_int_reg_wb
// Self-checking bench for int_reg_wb. A queue-based reference model tracks
// the load queue, scoreboard and expected write port; directed sequences are
// followed by a randomized phase.
// ----------------------------------------------------------------------------
module tb_int_reg_wb;
    import cpu_pkg::*;

    localparam int LQ_DEPTH = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_data;
    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [REG_ADDR_W-1:0] lsu_rd;
    logic [XLEN-1:0]       lsu_data;
    logic                  iss_load;
    logic [REG_ADDR_W-1:0] iss_rd;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic                  rs1_busy;
    logic                  rs2_busy;
    logic                  rd_wen;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]       rd_wdata;

    always #5 clk = ~clk;

    int_reg_wb #(.LQ_DEPTH(LQ_DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .iss_load  (iss_load),
        .iss_rd    (iss_rd),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .rd_wen    (rd_wen),
        .rd_addr   (rd_addr),
        .rd_wdata  (rd_wdata)
    );

    typedef struct {
        bit        rst;
        bit        alu_valid;
        bit [4:0]  alu_rd;
        bit [31:0] alu_data;
        bit        lsu_valid;
        bit [4:0]  lsu_rd;
        bit [31:0] lsu_data;
        bit        iss_load;
        bit [4:0]  iss_rd;
        bit [4:0]  rs1;
        bit [4:0]  rs2;
    } stim_t;

    // Reference model state: the load queue as a plain queue, the scoreboard
    // as a bit per register, and the write port value expected after the edge.
    wb_req_t   model_q[$];
    bit        model_busy[32];
    bit        exp_wen;
    bit [4:0]  exp_addr;
    bit [31:0] exp_data;
    bit        addr_known;
    bit        model_valid;

    int total_checks = 0;
    int bad_checks   = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    // One clock cycle: drive after the falling edge, check the combinational
    // outputs against the pre-edge model, advance the model, then check the
    // registered outputs just after the rising edge.
    task automatic applyStimulus(input stim_t s);
        wb_req_t e;
        bit      accept;
        @(negedge clk);
        rst       = s.rst;
        alu_valid = s.alu_valid;
        alu_rd    = s.alu_rd;
        alu_data  = s.alu_data;
        lsu_valid = s.lsu_valid;
        lsu_rd    = s.lsu_rd;
        lsu_data  = s.lsu_data;
        iss_load  = s.iss_load;
        iss_rd    = s.iss_rd;
        rs1_addr  = s.rs1;
        rs2_addr  = s.rs2;
        #1;
        if (model_valid) begin
            checkOutput("lsu_ready", lsu_ready, model_q.size() < LQ_DEPTH);
            checkOutput("rs1_busy",  rs1_busy,  model_busy[s.rs1]);
            checkOutput("rs2_busy",  rs2_busy,  model_busy[s.rs2]);
        end
        if (s.rst) begin
            model_q.delete();
            foreach (model_busy[i]) model_busy[i] = 0;
            exp_wen     = 0;
            exp_addr    = 0;
            exp_data    = 0;
            addr_known  = 1;
            model_valid = 1;
        end else if (model_valid) begin
            accept = s.lsu_valid && (model_q.size() < LQ_DEPTH);
            if (s.alu_valid) begin
                exp_wen    = (s.alu_rd != 0);
                exp_addr   = s.alu_rd;
                exp_data   = s.alu_data;
                addr_known = (s.alu_rd != 0);
            end else if (model_q.size() > 0) begin
                e = model_q.pop_front();
                exp_wen    = (e.rd != 0);
                exp_addr   = e.rd;
                exp_data   = e.data;
                addr_known = (e.rd != 0);
                model_busy[e.rd] = 0;
            end else begin
                exp_wen = 0;
            end
            if (accept) begin
                e.rd   = s.lsu_rd;
                e.data = s.lsu_data;
                model_q.push_back(e);
            end
            if (s.iss_load && s.iss_rd != 0) begin
                model_busy[s.iss_rd] = 1;
            end
        end
        @(posedge clk);
        #1;
        if (model_valid) begin
            checkOutput("rd_wen", rd_wen, exp_wen);
            if (addr_known) begin
                checkOutput("rd_addr",  rd_addr,  exp_addr);
                checkOutput("rd_wdata", rd_wdata, exp_data);
            end
        end
    endtask

    initial begin
        stim_t s;
        int    load_idx;
        model_valid = 0;

        // Reset, then scan every register address for a clear scoreboard.
        s = idle();
        s.rst = 1;
        applyStimulus(s);
        applyStimulus(s);
        for (int i = 0; i < 32; i++) begin
            s = idle();
            s.rs1 = 5'(i);
            s.rs2 = 5'(31 - i);
            applyStimulus(s);
        end

        // Single ALU write.
        s = idle();
        s.alu_valid = 1; s.alu_rd = 5; s.alu_data = 32'hDEADBEEF;
        applyStimulus(s);
        checkOutput("alu_x5_data", rd_wdata, 32'hDEADBEEF);
        applyStimulus(idle());

        // Issued load to x7, returned three cycles later.
        s = idle(); s.iss_load = 1; s.iss_rd = 7; s.rs1 = 7;
        applyStimulus(s);
        s = idle(); s.rs1 = 7;
        for (int i = 0; i < 3; i++) applyStimulus(s);
        s = idle(); s.lsu_valid = 1; s.lsu_rd = 7; s.lsu_data = 32'h12345678; s.rs1 = 7;
        applyStimulus(s);
        s = idle(); s.rs1 = 7;
        for (int i = 0; i < 3; i++) applyStimulus(s);

        // Six ALU cycles while the LSU offers five loads with a real handshake.
        load_idx = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            s = idle();
            if (cyc < 6) begin
                s.alu_valid = 1; s.alu_rd = 5'(10 + cyc); s.alu_data = 32'hA000_0000 + cyc;
            end
            if (load_idx < 5) begin
                s.lsu_valid = 1; s.lsu_rd = 5'(20 + load_idx); s.lsu_data = 32'hB000_0000 + load_idx;
            end
            if (s.lsu_valid && model_q.size() < LQ_DEPTH) load_idx++;
            applyStimulus(s);
        end

        // Pop of x9 coincides with a new load issued to x9.
        s = idle(); s.iss_load = 1; s.iss_rd = 9; s.rs1 = 9;
        applyStimulus(s);
        s = idle(); s.lsu_valid = 1; s.lsu_rd = 9; s.lsu_data = 32'h0000_0909; s.rs1 = 9;
        applyStimulus(s);
        s = idle(); s.iss_load = 1; s.iss_rd = 9; s.rs1 = 9;
        applyStimulus(s);
        s = idle(); s.rs1 = 9;
        applyStimulus(s);
        checkOutput("x9_still_busy", rs1_busy, 1'b1);
        s = idle(); s.lsu_valid = 1; s.lsu_rd = 9; s.lsu_data = 32'h0000_0999; s.rs1 = 9;
        applyStimulus(s);
        s = idle(); s.rs1 = 9;
        for (int i = 0; i < 3; i++) applyStimulus(s);

        // Writes aimed at x0 never raise the enable.
        s = idle(); s.alu_valid = 1; s.alu_rd = 0; s.alu_data = 32'hFFFF_FFFF;
        applyStimulus(s);
        s = idle(); s.lsu_valid = 1; s.lsu_rd = 0; s.lsu_data = 32'h5555_5555;
        applyStimulus(s);
        applyStimulus(idle());
        applyStimulus(idle());

        // Reset with three loads queued behind ALU traffic and x3 pending.
        for (int i = 0; i < 3; i++) begin
            s = idle();
            s.alu_valid = 1; s.alu_rd = 5'(1 + i); s.alu_data = 32'hC000_0000 + i;
            s.lsu_valid = 1; s.lsu_rd = 5'(3 + i); s.lsu_data = 32'hD000_0000 + i;
            s.iss_load = (i == 0); s.iss_rd = 3;
            applyStimulus(s);
        end
        s = idle(); s.rst = 1; s.rs1 = 3;
        applyStimulus(s);
        s = idle(); s.rs1 = 3;
        for (int i = 0; i < 5; i++) applyStimulus(s);
        checkOutput("post_reset_wen", rd_wen, 1'b0);

        // Randomized traffic.
        for (int cyc = 0; cyc < 600; cyc++) begin
            s = idle();
            s.rst       = ($urandom_range(0, 199) == 0);
            s.alu_valid = ($urandom_range(0, 99) < 40);
            s.alu_rd    = 5'($urandom);
            s.alu_data  = $urandom;
            s.lsu_valid = ($urandom_range(0, 99) < 50);
            s.lsu_rd    = 5'($urandom);
            s.lsu_data  = $urandom;
            s.iss_load  = ($urandom_range(0, 99) < 30);
            s.iss_rd    = 5'($urandom);
            s.rs1       = 5'($urandom);
            s.rs2       = 5'($urandom);
            applyStimulus(s);
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
